mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Load/store execution stage (phases P3–P5 of the multi-cycle core) for LD/ST instructions, i.e. opcode[15:14] = 00 or 01.
- Sits directly downstream of the controller's operand fetch (P2): takes the base register, displacement, store data and destination register.
- Computes the effective address and drives the single-port synchronous main memory.
- For loads, captures the read data into MDR and issues a one-cycle register-file writeback.

Parameters:
- DATA_WIDTH, 16, memory and register data width.
- ADDR_WIDTH, 16, memory address width.
- DISP_WIDTH, 8, displacement width; the displacement is sign-extended to ADDR_WIDTH.
- REG_SEL_WIDTH, 3, register-file index width.
- READ_LATENCY, 1, edges from memory sampling its address to q being valid; legal range 1..3.

Ports:
- clock  in  1  single system clock, all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- is_store  in  1  1 = ST, 0 = LD; sampled with start.
- base  in  ADDR_WIDTH  base address (AR).
- disp  in  DISP_WIDTH  signed displacement (IR[7:0]).
- store_data  in  DATA_WIDTH  value to write for ST.
- dest_reg  in  REG_SEL_WIDTH  load destination (IR[13:11]); ignored for ST.
- mem_address  out  ADDR_WIDTH  registered memory address.
- mem_write_data  out  DATA_WIDTH  registered write data.
- mem_wren  out  1  registered write enable.
- mem_q  in  DATA_WIDTH  memory read data.
- mdr  out  DATA_WIDTH  memory data register, holds the last load value.
- wb_enable  out  1  one-cycle register-file write strobe.
- wb_reg  out  REG_SEL_WIDTH  writeback index.
- wb_data  out  DATA_WIDTH  writeback value; equals mdr.
- busy  out  1  high from the cycle after acceptance through the done cycle, inclusive.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, immediate): state IDLE. All outputs 0: mem_address, mem_write_data, mem_wren, mdr, wb_enable, wb_reg, wb_data, busy, done. Wait counter 0.
- Reset asserted mid-operation: mem_wren drops immediately and the operation is abandoned. No writeback or done is produced after release.
- Effective address: EA = (base + sext(disp)) mod 2^ADDR_WIDTH. Wrap-around in both directions is silent; there is no flag.
- States: IDLE, RD_ADDR, RD_WAIT, RD_CAPT, WB, WR, WR_DONE.
- IDLE:
  - start=0: stay in IDLE.
  - start=1, is_store=0: mem_address<=EA, latch dest_reg into wb_reg, mem_wren held 0, go to RD_ADDR.
  - start=1, is_store=1: mem_address<=EA, mem_write_data<=store_data, mem_wren<=1, go to WR.
- RD_ADDR: memory samples the address on this edge. Load counter with READ_LATENCY-1. Go to RD_WAIT if the counter is nonzero, else RD_CAPT.
- RD_WAIT: decrement the counter; go to RD_CAPT when it reaches 0.
- RD_CAPT: mdr<=mem_q, wb_data<=mem_q, wb_enable<=1, done<=1, go to WB.
- WB: this is the done cycle. wb_enable, done and busy are high for exactly this cycle. Clear the strobes and return to IDLE.
- WR: mem_wren is high for exactly this one cycle; the memory writes on the closing edge. mem_wren<=0, done<=1, go to WR_DONE.
- WR_DONE: this is the done cycle. Clear done and return to IDLE. wb_enable stays 0 and mdr is unchanged.
- Load latency: start sampled at edge N gives wb_enable/done high in the cycle after edge N+1+READ_LATENCY. For READ_LATENCY=1 that is after edge N+2.
- Store latency: mem_wren is high in the cycle after edge N; done is high in the cycle after edge N+1.
- busy=0 only in IDLE.
- start while busy, including in the done cycle, is ignored with no queueing. Back-to-back throughput is one op per (latency+1) cycles.
- Inputs other than mem_q are sampled only at acceptance; later changes have no effect.
- mem_address and mem_write_data hold their last values in IDLE.
- A load from the address just stored returns the new data. The write completes before any later read is issued.

Test Plan:
- Reset then idle: reset_n=0 mid-run -> all outputs 0 at once; after release busy=0 and no done for 10 cycles with start=0.
- Store: base=0x0010, disp=0x05, store_data=0xBEEF, start at edge N -> mem_address=0x0015 and mem_wren=1 for exactly the cycle after N; done pulses the cycle after N+1; wb_enable stays 0.
- Load with negative displacement: base=0x0015, disp=0xFB (−5), dest_reg=3, model memory[0x0010]=0x1234 -> mem_address=0x0010; done, wb_enable=1, wb_reg=3, wb_data=mdr=0x1234 in the cycle after N+2.
- Wrap-around: base=0xFFFE, disp=0x04 -> EA=0x0002. base=0x0001, disp=0x80 -> EA=0xFF81.
- Busy rejection and back-to-back: start pulsed every cycle during a load -> only the first is accepted. A store 0xA5A5 to 0x0020 followed by a load of 0x0020 -> mdr=0xA5A5.
- READ_LATENCY=3 build: load accepted at edge N -> done in the cycle after edge N+4; mem_wren is asserted mid-store and reset_n pulsed -> mem_wren=0 at once and no done.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Bundles the load/store stage's request side (from operand fetch), its
//   main-memory side and its writeback/status side into one interface.
//
//   slave  modport : used by the stage itself.
//   master modport : used by whatever sits around the stage (controller,
//                    memory, register file).
//
//   Request : start, is_store, base, disp, store_data, dest_reg
//   Memory  : mem_address, mem_write_data, mem_wren (to memory), mem_q (from memory)
//   Result  : mdr, wb_enable, wb_reg, wb_data, busy, done
interface mem_access_stage_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int DISP_WIDTH    = 8,
  parameter int REG_SEL_WIDTH = 3
);
  logic                     start;
  logic                     is_store;
  logic [ADDR_WIDTH-1:0]    base;
  logic [DISP_WIDTH-1:0]    disp;
  logic [DATA_WIDTH-1:0]    store_data;
  logic [REG_SEL_WIDTH-1:0] dest_reg;

  logic [ADDR_WIDTH-1:0]    mem_address;
  logic [DATA_WIDTH-1:0]    mem_write_data;
  logic                     mem_wren;
  logic [DATA_WIDTH-1:0]    mem_q;

  logic [DATA_WIDTH-1:0]    mdr;
  logic                     wb_enable;
  logic [REG_SEL_WIDTH-1:0] wb_reg;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, is_store, base, disp, store_data, dest_reg, mem_q,
    output mem_address, mem_write_data, mem_wren,
    output mdr, wb_enable, wb_reg, wb_data, busy, done
  );

  modport master (
    output start, is_store, base, disp, store_data, dest_reg, mem_q,
    input  mem_address, mem_write_data, mem_wren,
    input  mdr, wb_enable, wb_reg, wb_data, busy, done
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Load/store execution stage of the multi-cycle core. Accepts one LD or ST
//   from operand fetch, forms the effective address base + sext(disp), drives
//   a single-port synchronous memory and, for loads, captures the read data
//   into MDR and issues a one-cycle register-file writeback.
//
//   clock   : system clock, all state changes on its rising edge
//   reset_n : asynchronous active-low reset, abandons any operation
//   bus     : mem_access_stage_if.slave (request, memory and result signals)
module mem_access_stage #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int DISP_WIDTH    = 8,
  parameter int REG_SEL_WIDTH = 3,
  parameter int READ_LATENCY  = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  mem_access_stage_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_WAIT, RD_CAPT, WB, WR, WR_DONE
  } state_t;

  // Extra wait cycles after the memory has sampled the address.
  localparam logic [1:0] LP_WAIT_INIT = 2'(READ_LATENCY - 1);

  state_t                   r_state, w_stateNext;
  logic [ADDR_WIDTH-1:0]    r_memAddress, w_memAddressNext;
  logic [DATA_WIDTH-1:0]    r_memWriteData, w_memWriteDataNext;
  logic                     r_memWren, w_memWrenNext;
  logic [DATA_WIDTH-1:0]    r_mdr, w_mdrNext;
  logic                     r_wbEnable, w_wbEnableNext;
  logic [REG_SEL_WIDTH-1:0] r_wbReg, w_wbRegNext;
  logic                     r_done, w_doneNext;
  logic [1:0]               r_waitCnt, w_waitCntNext;
  logic [ADDR_WIDTH-1:0]    w_effAddr;

  // Displacement is sign-extended; overflow simply wraps.
  assign w_effAddr = bus.base + {{(ADDR_WIDTH-DISP_WIDTH){bus.disp[DISP_WIDTH-1]}}, bus.disp};

  // State and all registered outputs; reset clears everything at once so a
  // pending write is dropped immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_memAddress   <= '0;
      r_memWriteData <= '0;
      r_memWren      <= 1'b0;
      r_mdr          <= '0;
      r_wbEnable     <= 1'b0;
      r_wbReg        <= '0;
      r_done         <= 1'b0;
      r_waitCnt      <= '0;
    end else begin
      r_state        <= w_stateNext;
      r_memAddress   <= w_memAddressNext;
      r_memWriteData <= w_memWriteDataNext;
      r_memWren      <= w_memWrenNext;
      r_mdr          <= w_mdrNext;
      r_wbEnable     <= w_wbEnableNext;
      r_wbReg        <= w_wbRegNext;
      r_done         <= w_doneNext;
      r_waitCnt      <= w_waitCntNext;
    end
  end

  // Next-state and next-output logic. Request inputs are only looked at in
  // IDLE, so a start arriving while busy is simply dropped.
  always_comb begin
    w_stateNext        = r_state;
    w_memAddressNext   = r_memAddress;
    w_memWriteDataNext = r_memWriteData;
    w_memWrenNext      = r_memWren;
    w_mdrNext          = r_mdr;
    w_wbEnableNext     = r_wbEnable;
    w_wbRegNext        = r_wbReg;
    w_doneNext         = r_done;
    w_waitCntNext      = r_waitCnt;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_memAddressNext = w_effAddr;
          if (bus.is_store) begin
            w_memWriteDataNext = bus.store_data;
            w_memWrenNext      = 1'b1;
            w_stateNext        = WR;
          end else begin
            w_wbRegNext = bus.dest_reg;
            w_stateNext = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        w_waitCntNext = LP_WAIT_INIT;
        w_stateNext   = (LP_WAIT_INIT != 2'd0) ? RD_WAIT : RD_CAPT;
      end
      RD_WAIT: begin
        // Leave once the counter is about to reach zero.
        w_waitCntNext = r_waitCnt - 2'd1;
        if (r_waitCnt <= 2'd1) begin
          w_stateNext = RD_CAPT;
        end
      end
      RD_CAPT: begin
        w_mdrNext      = bus.mem_q;
        w_wbEnableNext = 1'b1;
        w_doneNext     = 1'b1;
        w_stateNext    = WB;
      end
      WB: begin
        w_wbEnableNext = 1'b0;
        w_doneNext     = 1'b0;
        w_stateNext    = IDLE;
      end
      WR: begin
        w_memWrenNext = 1'b0;
        w_doneNext    = 1'b1;
        w_stateNext   = WR_DONE;
      end
      WR_DONE: begin
        w_doneNext  = 1'b0;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign bus.mem_address    = r_memAddress;
  assign bus.mem_write_data = r_memWriteData;
  assign bus.mem_wren       = r_memWren;
  assign bus.mdr            = r_mdr;
  assign bus.wb_enable      = r_wbEnable;
  assign bus.wb_reg         = r_wbReg;
  // Writeback data is the captured MDR value itself.
  assign bus.wb_data        = r_mdr;
  assign bus.done           = r_done;
  assign bus.busy           = (r_state != IDLE);

endmodule
